cs_resolve_serial: RTL and testbench
====================================

Name: cs_resolve_serial

Overview:
- Consumes the carry-save pair (C, S) produced by the squaring compressor tree.
- Resolves C + S into a single non-redundant binary value over several cycles, adding a fixed-width chunk per cycle with a registered carry chain.
- Emits the result as WORD_LEN-bit coefficient words, ready for reduction or feedback into the next squaring.
- Sits downstream of the squarer, at the other end of its C/S interface; it trades latency for a short carry path.

Parameters:
- NUM_ELEMENTS_OUT, 2112, width in bits of the C and S inputs.
- WORD_LEN, 17, bits per output coefficient word.
- WORDS_PER_CYCLE, 4, output words resolved per ADD cycle. The chunk width is WORD_LEN*WORDS_PER_CYCLE.
- NUM_WORDS (localparam), ceil(NUM_ELEMENTS_OUT/WORD_LEN) = 125, number of output words.
- NUM_CYCLES (localparam), ceil(NUM_WORDS/WORDS_PER_CYCLE) = 32, number of ADD cycles.

Ports:
- clk, input, 1, clock. All logic is rising-edge.
- reset, input, 1, synchronous active-high reset.
- in_valid, input, 1, C/S pair is valid.
- in_ready, output, 1, block can accept a C/S pair.
- C, input, NUM_ELEMENTS_OUT, carry vector.
- S, input, NUM_ELEMENTS_OUT, sum vector.
- out_valid, output, 1, out_words holds a complete result.
- out_ready, input, 1, downstream accepts the result.
- out_words, output, NUM_WORDS*WORD_LEN, resolved sum. Word i occupies bits [i*WORD_LEN +: WORD_LEN], least-significant word first.

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- FSM states: IDLE, ADD, DONE. Reset forces IDLE.
- Reset values:
  - out_valid = 0.
  - out_words = 0.
  - Cycle counter = 0.
  - Carry register = 0.
  - in_ready = 0 while reset is high.
- in_ready = 1 exactly when state is IDLE and reset is low. It is decoded from the registered state only; there is no combinational path from out_ready.
- IDLE:
  - On in_valid && in_ready, latch C and S into internal registers, zero-extended to NUM_WORDS*WORD_LEN (2125) bits.
  - Clear the counter and carry, then go to ADD.
- ADD, on each cycle k (0..NUM_CYCLES-1):
  - Compute chunk_k(C) + chunk_k(S) + carry, where each chunk is WORD_LEN*WORDS_PER_CYCLE = 68 bits at bit offset k*68.
  - Write the low 68 bits into the matching out_words slice.
  - Register bit 68 as the new carry.
  - The final chunk is partial (125 = 31*4 + 1 words). Slices beyond bit 2125 are ignored, and the adder is fed zeros there.
  - After cycle NUM_CYCLES-1, go to DONE with out_valid = 1.
- Latency: handshake accepted at edge t → out_valid high in the cycle after edge t+NUM_CYCLES, i.e. 32 clocks.
- Width rule: C + S < 2^2113 always fits in 2125 bits. Any carry out of the top chunk is discarded and is always 0.
- Partial writes are permitted: out_words may change during ADD. It is only meaningful while out_valid = 1.
- DONE:
  - Hold out_words and out_valid until out_ready = 1.
  - On out_valid && out_ready, clear out_valid and return to IDLE. in_ready rises the next cycle; there is no same-cycle turnaround.
- in_valid during ADD or DONE is ignored. C and S may change freely after acceptance.
- out_ready during IDLE or ADD is ignored.
- Reset mid-ADD or mid-DONE aborts the operation: state goes to IDLE, out_valid = 0, out_words = 0. The partial result is lost and nothing is emitted.
- reset has priority over all handshakes in the same cycle.

Test Plan:
- Zero input: C = 0, S = 0, accept, out_ready = 1 → out_valid asserted 32 cycles after acceptance, all out_words = 0; in_ready returns 1 one cycle after the output handshake.
- Full carry ripple: C = all 2112 ones, S = 1 → result is 2^2112. Word 124 = 0x10 (bit 4 set); words 0..123 = 0.
- Maximum sum: C = S = all ones → result is 2^2113 − 2. Word 0 = 0x1FFFE, words 1..123 = 0x1FFFF, word 124 = 0x1F.
- Backpressure: C = 0x3, S = 0x5, out_ready held low 5 cycles after out_valid → out_valid and out_words are stable throughout, with word 0 = 0x8; in_ready = 0 and a concurrent in_valid is ignored.
- Reset mid-operation: assert reset for 1 cycle at ADD cycle 10 → next cycle out_valid = 0, out_words = 0, in_ready = 1. A new pair C = 1, S = 1 then yields word 0 = 0x2.
- Back-to-back with random C/S pairs (≥100): out_ready tied high → each result matches a reference big-integer C + S; inter-result spacing is 34 cycles (acceptance, 32 ADD cycles, one DONE cycle).

Source files
------------

// File: rtl/cs_resolve_serial_if.sv
// Handshake bus between the squarer's carry-save output and the serial resolver.
interface cs_resolve_serial_if #(
    parameter int unsigned NUM_ELEMENTS_OUT = 2112,
    parameter int unsigned WORD_LEN         = 17
);
    localparam int unsigned NUM_WORDS = (NUM_ELEMENTS_OUT + WORD_LEN - 1) / WORD_LEN;
    localparam int unsigned OUT_W     = NUM_WORDS * WORD_LEN;

    logic                        in_valid;
    logic                        in_ready;
    logic [NUM_ELEMENTS_OUT-1:0] C;
    logic [NUM_ELEMENTS_OUT-1:0] S;
    logic                        out_valid;
    logic                        out_ready;
    logic [OUT_W-1:0]            out_words;

    // Upstream/downstream side: supplies C/S pairs and consumes results
    modport master (
        output in_valid, C, S, out_ready,
        input  in_ready, out_valid, out_words
    );

    // Resolver side
    modport slave (
        input  in_valid, C, S, out_ready,
        output in_ready, out_valid, out_words
    );
endinterface

// File: rtl/cs_resolve_serial.sv
// Serial carry-save resolver: adds C + S one chunk per cycle with a registered
// carry, producing NUM_WORDS coefficient words after NUM_CYCLES add cycles.
module cs_resolve_serial #(
    parameter int unsigned NUM_ELEMENTS_OUT = 2112,
    parameter int unsigned WORD_LEN         = 17,
    parameter int unsigned WORDS_PER_CYCLE  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    cs_resolve_serial_if.slave   bus
);
    localparam int unsigned NUM_WORDS  = (NUM_ELEMENTS_OUT + WORD_LEN - 1) / WORD_LEN;
    localparam int unsigned NUM_CYCLES = (NUM_WORDS + WORDS_PER_CYCLE - 1) / WORDS_PER_CYCLE;
    localparam int unsigned CHUNK_W    = WORD_LEN * WORDS_PER_CYCLE;
    localparam int unsigned OUT_W      = NUM_WORDS * WORD_LEN;
    localparam int unsigned PAD_W      = NUM_CYCLES * CHUNK_W;
    localparam int unsigned LAST_OFF   = (NUM_CYCLES - 1) * CHUNK_W;
    localparam int unsigned LAST_W     = OUT_W - LAST_OFF;
    localparam int unsigned CNT_W      = (NUM_CYCLES > 1) ? $clog2(NUM_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PAD_W-1:0]   c_q, c_d;
    logic [PAD_W-1:0]   s_q, s_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_c;
    logic               accept_c;
    logic [CHUNK_W:0]   sum_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_c) state_d = ST_ADD;
            ST_ADD:  if (cnt_q == LAST_CNT) state_d = ST_DONE;
            ST_DONE: if (bus.out_ready) state_d = ST_DONE == state_q ? ST_IDLE : state_q;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs and datapath next values; operands shift down so the adder
    // always reads the low chunk, results land in the chunk selected by cnt_q
    always_comb begin
        in_ready_c  = (state_q == ST_IDLE) && !reset;
        accept_c    = bus.in_valid && in_ready_c;
        c_d         = c_q;
        s_d         = s_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        sum_c       = {1'b0, c_q[CHUNK_W-1:0]} + {1'b0, s_q[CHUNK_W-1:0]}
                    + (CHUNK_W + 1)'(carry_q);

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    c_d     = PAD_W'(bus.C);
                    s_d     = PAD_W'(bus.S);
                    cnt_d   = '0;
                    carry_d = 1'b0;
                end
            end
            ST_ADD: begin
                c_d     = c_q >> CHUNK_W;
                s_d     = s_q >> CHUNK_W;
                carry_d = sum_c[CHUNK_W];
                cnt_d   = cnt_q + CNT_W'(1);
                for (int unsigned k = 0; k < NUM_CYCLES - 1; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        out_d[k*CHUNK_W +: CHUNK_W] = sum_c[CHUNK_W-1:0];
                    end
                end
                // Final chunk is partial; bits past the last word are dropped
                if (cnt_q == LAST_CNT) begin
                    out_d[LAST_OFF +: LAST_W] = sum_c[LAST_W-1:0];
                    out_valid_d               = 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) out_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            c_q         <= '0;
            s_q         <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            c_q         <= c_d;
            s_q         <= s_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_words = out_q;

endmodule

// File: tb/tb_cs_resolve_serial.sv
// Directed and random checks of the serial carry-save resolver.
module tb_cs_resolve_serial;
    localparam int unsigned NE = 2112;
    localparam int unsigned WL = 17;
    localparam int unsigned NW = 125;
    localparam int unsigned OW = NW * WL;
    localparam int NV = 7;

    typedef struct {
        string          name;
        logic [NE-1:0]  c;
        logic [NE-1:0]  s;
        logic [OW-1:0]  exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cs_resolve_serial_if bus ();

    cs_resolve_serial dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_words(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        int idx;
        idx = -1;
        total++;
        if (act !== exp) begin
            bad++;
            for (int i = NW - 1; i >= 0; i--)
                if (act[i*WL +: WL] !== exp[i*WL +: WL]) idx = i;
            if (idx >= 0)
                $display("FAIL %s word %0d act=%h exp=%h", nm, idx,
                         act[idx*WL +: WL], exp[idx*WL +: WL]);
            else
                $display("FAIL %s act has X/Z bits", nm);
        end
    endtask

    function automatic logic [NE-1:0] rand_vec(input bit heavy);
        logic [NE-1:0] v;
        for (int i = 0; i < NE / 32; i++) begin
            v[i*32 +: 32] = $urandom;
            if (heavy && ($urandom_range(0, 3) == 0)) v[i*32 +: 32] = '1;
        end
        return v;
    endfunction

    // Offer one pair, wait for the result; out_ready is left to the caller
    task automatic run_op(input logic [NE-1:0] c, input logic [NE-1:0] s,
                          output logic [OW-1:0] res, output int lat, output int acc);
        int w;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 50) begin
            step();
            w++;
        end
        chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.C        = c;
        bus.S        = s;
        step();
        acc          = cyc;
        bus.in_valid = 1'b0;
        bus.C        = rand_vec(1'b0);
        bus.S        = ~c;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
        res = bus.out_words;
    endtask

    vec_t           vecs[NV];
    logic [NE-1:0]  one_ne;
    logic [NE-1:0]  ones_ne;
    logic [OW-1:0]  one_ow;
    logic [OW-1:0]  res;
    logic [OW-1:0]  exp_v;
    logic [NE-1:0]  rc, rs;
    int             lat, acc, prev;

    initial begin
        one_ne  = NE'(1);
        ones_ne = '1;
        one_ow  = OW'(1);

        vecs[0].name = "zero";        vecs[0].c = '0;      vecs[0].s = '0;
        vecs[0].exp  = '0;
        vecs[1].name = "ripple";      vecs[1].c = ones_ne; vecs[1].s = one_ne;
        vecs[1].exp  = one_ow << 2112;
        vecs[2].name = "max_sum";     vecs[2].c = ones_ne; vecs[2].s = ones_ne;
        vecs[2].exp  = (one_ow << 2113) - OW'(2);
        vecs[3].name = "small";       vecs[3].c = NE'(3);  vecs[3].s = NE'(5);
        vecs[3].exp  = OW'(8);
        vecs[4].name = "chunk_carry"; vecs[4].c = (one_ne << 68) - NE'(1); vecs[4].s = one_ne;
        vecs[4].exp  = one_ow << 68;
        vecs[5].name = "top_bits";    vecs[5].c = one_ne << 2111; vecs[5].s = one_ne << 2111;
        vecs[5].exp  = one_ow << 2112;
        vecs[6].name = "word_carry";  vecs[6].c = NE'(17'h1FFFF); vecs[6].s = one_ne;
        vecs[6].exp  = OW'(18'h20000);

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.C         = '0;
        bus.S         = '0;
        repeat (3) step();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk_words("rst_out_words", bus.out_words, '0);
        reset = 1'b0;
        #1;
        chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

        // Table-driven directed vectors, out_ready held high
        bus.out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].c, vecs[i].s, res, lat, acc);
            chk({vecs[i].name, "_lat"}, 32'(lat), 32'd32);
            chk_words(vecs[i].name, res, vecs[i].exp);
            if (i == 1) chk("ripple_w124", 32'(res[124*WL +: WL]), 32'h10);
            if (i == 2) begin
                chk("max_w0", 32'(res[0 +: WL]), 32'h1FFFE);
                chk("max_w1", 32'(res[WL +: WL]), 32'h1FFFF);
                chk("max_w124", 32'(res[124*WL +: WL]), 32'h1F);
            end
            step();
            chk("valid_drop", 32'(bus.out_valid), 32'd0);
            chk("ready_back", 32'(bus.in_ready), 32'd1);
        end

        // Backpressure: result must hold while out_ready is low
        bus.out_ready = 1'b0;
        run_op(NE'(3), NE'(5), res, lat, acc);
        chk("bp_lat", 32'(lat), 32'd32);
        chk("bp_w0", 32'(res[0 +: WL]), 32'h8);
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.C        = rand_vec(1'b0);
            bus.S        = rand_vec(1'b0);
            step();
            chk("bp_valid_hold", 32'(bus.out_valid), 32'd1);
            chk_words("bp_words_hold", bus.out_words, OW'(8));
            chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
        step();
        chk("bp_no_spurious_op", 32'(bus.in_ready), 32'd1);

        // Reset at ADD cycle 10 aborts the operation
        bus.in_valid = 1'b1;
        bus.C        = rand_vec(1'b1);
        bus.S        = rand_vec(1'b1);
        step();
        bus.in_valid = 1'b0;
        repeat (10) step();
        chk("mid_busy", 32'(bus.in_ready), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("abort_valid", 32'(bus.out_valid), 32'd0);
        chk_words("abort_words", bus.out_words, '0);
        chk("abort_ready", 32'(bus.in_ready), 32'd1);
        run_op(one_ne, one_ne, res, lat, acc);
        chk("post_abort_lat", 32'(lat), 32'd32);
        chk_words("post_abort_result", res, OW'(2));
        step();

        // Back-to-back random pairs against a wide-integer reference
        prev = -1;
        for (int n = 0; n < 100; n++) begin
            rc    = rand_vec(n[0]);
            rs    = rand_vec(n[1]);
            exp_v = OW'(rc) + OW'(rs);
            run_op(rc, rs, res, lat, acc);
            chk("rand_lat", 32'(lat), 32'd32);
            chk_words("rand_result", res, exp_v);
            if (prev >= 0) chk("rand_spacing", 32'(acc - prev), 32'd34);
            prev = acc;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
